lcd_text_sequencer: RTL

Sequencing controller for the 16x2 HD44780-style character LCD on the `LCDCLK` domain. It runs the power-on wait and the init command sequence, then refreshes the display forever from an internal 32-byte character buffer. The buffer is written by the host through a simple single-cycle write port. The block owns all LCD pins (`LCD_RS`/`LCD_RW`/`LCD_EN`/`LCD_DATA`) and replaces free-running byte rotation with a command-aware, line-addressed frame schedule.

---
 rtl/lcd_text_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
//   Drives a 16x2 HD44780-style character LCD: power-on wait, init command
//   sequence, then an endless line-addressed refresh of a 32-byte character
//   buffer written by the host through a single-cycle write port.
//
//   Optional feature macro: LCD_FRAME_SYNC_EN
//     defined   - host writes land in a shadow buffer that is copied to the
//                 display buffer in the clock the sequencer enters HOME1, so
//                 every frame shows one consistent snapshot.
//     undefined - host writes go straight to the display buffer (a frame may
//                 mix old and new characters).
//
//   Bus cycle: cnt runs 0..T_CYCLE. RS/DATA are captured on the edge that
//   ends the cnt==0 clock and held for the rest of the cycle; EN is high
//   while T_SETUP < cnt <= T_SETUP+T_EN. EN is registered from the next
//   counter value so the pin is glitch-free and still tracks cnt exactly.
//
//   T_PWRON and T_CLEAR must be at least 1; T_CYCLE must exceed
//   T_SETUP+T_EN.

module lcd_text_sequencer #(
   parameter int T_SETUP = 200,
   parameter int T_EN    = 1600,
   parameter int T_CYCLE = 2000,
   parameter int T_PWRON = 20000,
   parameter int T_CLEAR = 4000
) (
   input  logic       LCDCLK,
   input  logic       PRESET,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       init_done,
   output logic       frame_done,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic [7:0] LCD_DATA
);

   // One counter serves the power-on wait, the clear wait and every bus
   // cycle, so it is sized for the largest of the three.
   localparam int CNT_M1  = (T_CYCLE > T_PWRON) ? T_CYCLE : T_PWRON;
   localparam int CNT_MAX = (CNT_M1 > T_CLEAR) ? CNT_M1 : T_CLEAR;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] CYC_LAST = CW'(T_CYCLE);
   localparam logic [CW-1:0] PWR_LAST = CW'(T_PWRON - 1);
   localparam logic [CW-1:0] CLR_LAST = CW'(T_CLEAR - 1);
   localparam logic [CW-1:0] EN_LO    = CW'(T_SETUP);
   localparam logic [CW-1:0] EN_HI    = CW'(T_SETUP + T_EN);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      ST_PWRON   = 3'd0,
      ST_INIT    = 3'd1,
      ST_CLRWAIT = 3'd2,
      ST_HOME1   = 3'd3,
      ST_LINE1   = 3'd4,
      ST_HOME2   = 3'd5,
      ST_LINE2   = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;     // init step in INIT, column in LINE1/LINE2
   logic          bus_end;
   logic          entering_home1;
   logic          cur_rs;
   logic [7:0]    cur_byte;
   logic [7:0]    disp [0:31];

   // States that run a bus cycle (EN pulse) as opposed to a plain wait.
   function automatic logic is_bus(input state_t s);
      return (s == ST_INIT)  || (s == ST_HOME1) || (s == ST_LINE1) ||
             (s == ST_HOME2) || (s == ST_LINE2);
   endfunction

   assign bus_end        = (cnt_q == CYC_LAST);
   assign entering_home1 = (state_d == ST_HOME1) && (state_q != ST_HOME1);
   assign frame_done     = (state_q == ST_LINE2) && (idx_q == 4'hF) && bus_end;
   assign LCD_RW         = 1'b0;

   // Sequencer state, wait/bus counter and byte index registers.
   always_ff @(posedge LCDCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= ST_PWRON;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Next state: waits end on their own terminal count, bus states advance
   // only at the last count of a bus cycle. The column index is 4 bits and
   // wraps 15->0 as the line changes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      idx_d   = idx_q;
      case (state_q)
         ST_PWRON: begin
            if (cnt_q == PWR_LAST) begin
               state_d = ST_INIT;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         ST_INIT: begin
            if (bus_end) begin
               cnt_d = '0;
               if (idx_q == 4'd3) begin
                  state_d = ST_CLRWAIT;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_CLRWAIT: begin
            if (cnt_q == CLR_LAST) begin
               state_d = ST_HOME1;
               cnt_d   = '0;
            end
         end
         ST_HOME1: begin
            if (bus_end) begin
               state_d = ST_LINE1;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         ST_LINE1: begin
            if (bus_end) begin
               cnt_d = '0;
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'hF) state_d = ST_HOME2;
            end
         end
         ST_HOME2: begin
            if (bus_end) begin
               state_d = ST_LINE2;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         ST_LINE2: begin
            if (bus_end) begin
               cnt_d = '0;
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'hF) state_d = ST_HOME1;
            end
         end
         default: begin
            state_d = ST_PWRON;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Byte and register-select for the bus cycle of the current state.
   always_comb begin
      cur_rs   = 1'b0;
      cur_byte = 8'h00;
      case (state_q)
         ST_INIT: begin
            case (idx_q[1:0])
               2'd0:    cur_byte = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
               2'd1:    cur_byte = 8'h0E;   // display on, cursor on
               2'd2:    cur_byte = 8'h06;   // entry mode: increment
               default: cur_byte = 8'h01;   // clear display
            endcase
         end
         ST_HOME1: cur_byte = 8'h80;        // DDRAM address line 1 col 0
         ST_HOME2: cur_byte = 8'hC0;        // DDRAM address line 2 col 0
         ST_LINE1: begin
            cur_rs   = 1'b1;
            cur_byte = disp[{1'b0, idx_q}];
         end
         ST_LINE2: begin
            cur_rs   = 1'b1;
            cur_byte = disp[{1'b1, idx_q}];
         end
         default: begin
            cur_rs   = 1'b0;
            cur_byte = 8'h00;
         end
      endcase
   end

   // LCD pins and init_done. RS/DATA are captured once per bus cycle and
   // then held; reading the buffer here sees the value from before any
   // write landing on the same edge.
   always_ff @(posedge LCDCLK or posedge PRESET) begin
      if (PRESET) begin
         LCD_RS    <= 1'b0;
         LCD_DATA  <= 8'h00;
         LCD_EN    <= 1'b0;
         init_done <= 1'b0;
      end else begin
         if (is_bus(state_q) && (cnt_q == '0)) begin
            LCD_RS   <= cur_rs;
            LCD_DATA <= cur_byte;
         end
         LCD_EN <= is_bus(state_d) && (cnt_d > EN_LO) && (cnt_d <= EN_HI);
         if (state_d == ST_HOME1) init_done <= 1'b1;
      end
   end

`ifdef LCD_FRAME_SYNC_EN
   logic [7:0] shadow [0:31];

   // Host writes always land in the shadow buffer.
   always_ff @(posedge LCDCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
      end else if (wr_en) begin
         shadow[wr_addr] <= wr_data;
      end
   end

   // Whole-buffer snapshot at the start of each frame; a write in the same
   // clock is not part of it and shows one frame later.
   always_ff @(posedge LCDCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < 32; i++) disp[i] <= 8'h20;
      end else if (entering_home1) begin
         for (int i = 0; i < 32; i++) disp[i] <= shadow[i];
      end
   end
`else
   // Host writes go straight to the display buffer.
   always_ff @(posedge LCDCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < 32; i++) disp[i] <= 8'h20;
      end else if (wr_en) begin
         disp[wr_addr] <= wr_data;
      end
   end
`endif

endmodule
